// File: rtl/vote_result_tx_if.sv
// Signal bundle between the result-mode controller and the UART result transmitter.
// The controller side owns the request and tallies; the transmitter owns the line and status.
interface vote_result_tx_if;
  logic       mode;
  logic       send_req;
  logic [7:0] cand1_vote_recvd;
  logic [7:0] cand2_vote_recvd;
  logic [7:0] cand3_vote_recvd;
  logic [7:0] cand4_vote_recvd;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output mode, send_req,
    output cand1_vote_recvd, cand2_vote_recvd, cand3_vote_recvd, cand4_vote_recvd,
    input  tx, busy, done
  );

  modport slave (
    input  mode, send_req,
    input  cand1_vote_recvd, cand2_vote_recvd, cand3_vote_recvd, cand4_vote_recvd,
    output tx, busy, done
  );
endinterface

// File: rtl/vote_result_tx.sv
// UART transmitter that ships a 6-byte result packet: header, four tallies, XOR checksum.
// Frames are 8N1, LSB first, back to back with no inter-byte gap; all outputs registered.
module vote_result_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input logic              clock,
  input logic              reset,
  vote_result_tx_if.slave  bus
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d, baud_next;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;
  logic              baud_wrap;
  logic [7:0]        snap1, snap2, snap3, snap4;
  logic [7:0]        checksum;
  logic [7:0]        cur_byte;

  assign checksum  = snap1 ^ snap2 ^ snap3 ^ snap4;
  assign baud_wrap = (baud_q == BAUD_LAST);
  assign baud_next = baud_wrap ? '0 : baud_q + BAUD_W'(1);

  // Next-state logic for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        idx_d  = '0;
        if (bus.send_req && bus.mode) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: begin
        baud_d = baud_next;
        if (baud_wrap) state_d = DATA;
      end
      DATA: begin
        baud_d = baud_next;
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_d = baud_next;
        if (baud_wrap) begin
          if (idx_q == 3'd5) begin
            state_d = DONE;
          end else begin
            state_d = START;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops with the state itself.
  always_comb begin
    cur_byte = checksum;
    case (idx_d)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = snap1;
      3'd2:    cur_byte = snap2;
      3'd3:    cur_byte = snap3;
      3'd4:    cur_byte = snap4;
      default: cur_byte = checksum;
    endcase
    tx_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      START:   begin tx_d = 1'b0;            busy_d = 1'b1; end
      DATA:    begin tx_d = cur_byte[bit_d]; busy_d = 1'b1; end
      STOP:    busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: snapshot registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clock) begin
    if (load) begin
      snap1 <= bus.cand1_vote_recvd;
      snap2 <= bus.cand2_vote_recvd;
      snap3 <= bus.cand3_vote_recvd;
      snap4 <= bus.cand4_vote_recvd;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_vote_result_tx.sv
// Directed bench for vote_result_tx at 4 clocks per bit: framing, snapshot,
// gating, busy-ignore, mid-packet reset and back-to-back requests.
module tb_vote_result_tx;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  vote_result_tx_if bus_if ();

  vote_result_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Entered in the first start-bit cycle; leaves in the DONE cycle.
  task automatic run_packet(input string name, input logic [47:0] exp,
                            input int change_at, input int pulse_at);
    int         k;
    logic       bitv;
    logic [3:0] seen;
    logic       bz;
    k = 0;
    for (int b = 0; b < 6; b++) begin
      for (int s = 0; s < 10; s++) begin
        if (s == 0)      bitv = 1'b0;
        else if (s == 9) bitv = 1'b1;
        else             bitv = exp[8*b + s - 1];
        seen = '0;
        bz   = 1'b1;
        for (int c = 0; c < 4; c++) begin
          seen[c] = bus_if.tx;
          if (!(bus_if.busy === 1'b1 && bus_if.done === 1'b0)) bz = 1'b0;
          if (k == change_at) bus_if.cand1_vote_recvd = 8'd9;
          if (pulse_at >= 0 && k == pulse_at)     bus_if.send_req = 1'b1;
          if (pulse_at >= 0 && k == pulse_at + 1) bus_if.send_req = 1'b0;
          k++;
          tick(1);
        end
        check($sformatf("%s byte%0d slot%0d tx", name, b, s), 32'(seen), 32'({4{bitv}}));
        check($sformatf("%s byte%0d slot%0d busy", name, b, s), 32'(bz), 32'd1);
      end
    end
    check({name, " done_pulse"}, 32'(bus_if.done), 32'd1);
    check({name, " done_busy"},  32'(bus_if.busy), 32'd0);
    check({name, " done_tx"},    32'(bus_if.tx),   32'd1);
  endtask

  initial begin
    logic any_low;
    logic any_busy;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus_if.mode             = 1'b0;
    bus_if.send_req         = 1'b0;
    bus_if.cand1_vote_recvd = 8'd3;
    bus_if.cand2_vote_recvd = 8'd5;
    bus_if.cand3_vote_recvd = 8'd0;
    bus_if.cand4_vote_recvd = 8'd255;
    tick(3);
    check("reset tx",   32'(bus_if.tx),   32'd1);
    check("reset busy", 32'(bus_if.busy), 32'd0);
    check("reset done", 32'(bus_if.done), 32'd0);
    reset = 1'b0;
    tick(2);

    // Request held with mode low must be ignored.
    bus_if.send_req = 1'b1;
    any_low  = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus_if.tx !== 1'b1)   any_low  = 1'b1;
      if (bus_if.busy !== 1'b0) any_busy = 1'b1;
    end
    check("gate tx_low",  32'(any_low),  32'd0);
    check("gate busy",    32'(any_busy), 32'd0);

    // Raising mode lets the held request through on the next edge.
    bus_if.mode = 1'b1;
    tick(1);
    bus_if.send_req = 1'b0;
    run_packet("pkt1", {8'hF9, 8'hFF, 8'h00, 8'h05, 8'h03, 8'hA5}, -1, -1);
    tick(1);
    check("pkt1 done_one_cycle", 32'(bus_if.done), 32'd0);

    // Snapshot isolation plus a request pulse while busy.
    tick(3);
    bus_if.send_req = 1'b1;
    tick(1);
    bus_if.send_req = 1'b0;
    run_packet("pkt2", {8'hF9, 8'hFF, 8'h00, 8'h05, 8'h03, 8'hA5}, 9, 39);
    tick(1);
    check("pkt2 done_one_cycle", 32'(bus_if.done), 32'd0);
    tick(3);
    check("pkt2 not_queued busy", 32'(bus_if.busy), 32'd0);
    check("pkt2 not_queued tx",   32'(bus_if.tx),   32'd1);

    // Reset mid-packet, asserted together with a request.
    bus_if.cand1_vote_recvd = 8'd3;
    bus_if.send_req = 1'b1;
    tick(1);
    bus_if.send_req = 1'b0;
    tick(28);
    check("mid busy",    32'(bus_if.busy), 32'd1);
    check("mid tx_data", 32'(bus_if.tx),   32'd0);
    reset = 1'b1;
    bus_if.send_req = 1'b1;
    tick(1);
    check("rst_mid tx",   32'(bus_if.tx),   32'd1);
    check("rst_mid busy", 32'(bus_if.busy), 32'd0);
    check("rst_mid done", 32'(bus_if.done), 32'd0);
    reset = 1'b0;
    bus_if.send_req = 1'b0;
    tick(1);
    check("rst_wins busy", 32'(bus_if.busy), 32'd0);
    tick(2);
    bus_if.cand1_vote_recvd = 8'd9;
    bus_if.send_req = 1'b1;
    tick(1);
    bus_if.send_req = 1'b0;
    run_packet("pkt3", {8'hF3, 8'hFF, 8'h00, 8'h05, 8'h09, 8'hA5}, -1, -1);
    tick(3);

    // Back-to-back with request held high.
    bus_if.cand1_vote_recvd = 8'h80;
    bus_if.cand2_vote_recvd = 8'h01;
    bus_if.cand3_vote_recvd = 8'h7E;
    bus_if.cand4_vote_recvd = 8'h55;
    bus_if.send_req = 1'b1;
    tick(1);
    run_packet("b2b_a", {8'hAA, 8'h55, 8'h7E, 8'h01, 8'h80, 8'hA5}, -1, -1);
    tick(1);
    check("b2b gap tx",   32'(bus_if.tx),   32'd1);
    check("b2b gap busy", 32'(bus_if.busy), 32'd0);
    check("b2b gap done", 32'(bus_if.done), 32'd0);
    tick(1);
    bus_if.send_req = 1'b0;
    run_packet("b2b_b", {8'hAA, 8'h55, 8'h7E, 8'h01, 8'h80, 8'hA5}, -1, -1);
    tick(3);
    check("final busy", 32'(bus_if.busy), 32'd0);
    check("final tx",   32'(bus_if.tx),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vote_result_tx.md
Name: vote_result_tx

Overview:
- Serial result-export transmitter: other end of the vote-collection path.
- Takes the four 8-bit candidate tallies produced by the vote logger and ships them off-chip as a framed UART packet on request.
- Sits beside the mode controller at top level; driven by the same clock and reset; active only in result mode (mode = 1).

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535
HEADER, 8'hA5, first byte of every packet

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  1 = result mode; requests accepted only when 1
send_req  input  1  level or pulse; sampled each cycle
cand1_vote_recvd  input  8  tally for candidate 1
cand2_vote_recvd  input  8  tally for candidate 2
cand3_vote_recvd  input  8  tally for candidate 3
cand4_vote_recvd  input  8  tally for candidate 4
tx  output  1  UART line; idle high
busy  output  1  high from acceptance through the end of the last stop bit
done  output  1  one-cycle pulse after packet completes

Behaviour:
- Reset values: tx = 1, busy = 0, done = 0, FSM = IDLE, bit counter = 0, byte index = 0, baud counter = 0.
- Acceptance:
  - Request accepted on the cycle where state = IDLE, send_req = 1 and mode = 1.
  - Requests while busy are ignored and not queued; requests with mode = 0 are ignored.
  - On acceptance, all four tallies are snapshotted into internal registers.
  - Checksum is computed from the snapshot: cand1 ^ cand2 ^ cand3 ^ cand4.
  - Later input changes do not affect the packet in flight.
- Packet: 6 bytes in order: HEADER, cand1, cand2, cand3, cand4, checksum.
- Byte frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- No inter-byte gap: the next start bit follows the previous stop bit directly.
- FSM states:
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if byte index < 5 (increment index).
  - STOP -> DONE if byte index = 5.
  - DONE -> IDLE after 1 cycle.
- Latency:
  - Acceptance at cycle N: busy = 1 and tx = 0 (start bit) from cycle N+1.
  - Total line time is 60*CLKS_PER_BIT cycles: tx returns to the final stop-bit value at N+1+59*CLKS_PER_BIT and holds 1.
  - busy falls and done = 1 at cycle N+1+60*CLKS_PER_BIT (DONE state); done lasts exactly one cycle.
  - A new request is accepted at the earliest on the cycle after DONE.
- Outputs are registered; tx has no combinational path from inputs.
- mode falling to 0 mid-packet does not abort; the packet completes.
- Reset asserted mid-packet: on the next edge, tx = 1, busy = 0, done = 0, state = IDLE. The partial packet is abandoned with no stop-bit completion.
- Reset and send_req asserted together: reset wins; nothing is accepted.
- Baud counter width: ceil(log2(CLKS_PER_BIT)) bits; it counts 0..CLKS_PER_BIT-1 and wraps.
- Tally values of 255 are transmitted as-is; no saturation or wrap logic lives in this block.

Test Plan:
- CLKS_PER_BIT = 4, mode = 1, tallies 3, 5, 0, 255, one-cycle send_req at cycle 10:
  - busy rises at cycle 11.
  - tx serial bytes are A5, 03, 05, 00, FF, F9, LSB first, each bit 4 cycles.
  - done pulses at cycle 251; busy = 0 from cycle 251.
- Snapshot isolation: same as above, but change cand1 to 9 at cycle 20 -> packet still carries 03 and checksum F9.
- Gating:
  - send_req held with mode = 0 for 100 cycles -> tx stays 1, busy stays 0.
  - Then set mode = 1 -> accepted next cycle.
- Busy ignore: second send_req pulse at cycle 50 during a packet -> exactly one packet (60 bit-times); done pulses once.
- Reset mid-packet: assert reset at cycle 40 for 1 cycle -> at cycle 41 tx = 1 and busy = 0; a new request at cycle 45 starts a clean packet beginning with A5.
- Back-to-back: send_req held high continuously -> consecutive packets separated by exactly one idle cycle (the DONE cycle) plus the acceptance cycle, with tx = 1 during that gap.
